apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_master_if.sv | 41 ++++
 rtl/apb4_master.sv | 132 +++++++++++++
 tb/tb_apb4_master.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/apb4_master_if.sv
// Bundle of the request/response handshake and APB4 bus signals used by apb4_master.
// The master modport is the bridge's view; the slave modport is the surrounding environment.
interface apb4_master_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic                      i_req;
    logic                      i_req_is_wr;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic [DATA_WIDTH-1:0]     i_wr_data;
    logic [DATA_WIDTH-1:0]     i_wr_biten;
    logic                      o_req_ready;
    logic                      o_rsp_valid;
    logic [DATA_WIDTH-1:0]     o_rsp_rd_data;
    logic                      o_rsp_err;

    logic [ADDR_WIDTH-1:0]     paddr;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        input  i_req, i_req_is_wr, i_addr, i_wr_data, i_wr_biten,
        output o_req_ready, o_rsp_valid, o_rsp_rd_data, o_rsp_err,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        output i_req, i_req_is_wr, i_addr, i_wr_data, i_wr_biten,
        input  o_req_ready, o_rsp_valid, o_rsp_rd_data, o_rsp_err,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_master.sv
// Single-outstanding request-to-APB4 bridge: IDLE -> SETUP -> ACCESS with an optional
// watchdog that ends a stalled ACCESS phase with an error response.
module apb4_master #(
    parameter int         ADDR_WIDTH     = 3,
    parameter int         DATA_WIDTH     = 32,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [2:0] PPROT_VAL      = 3'b000
) (
    input  logic          clk,
    input  logic          rst,
    apb4_master_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Value of the counter during the last permitted ACCESS cycle without pready.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        wait_cnt_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic [STRB_W-1:0]       pstrb_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rd_data_r;
    logic                    rsp_err_r;
    logic                    timeout_hit_s;

    // A byte lane is strobed when any of its bit enables is set.
    function automatic logic [STRB_W-1:0] strb_from_biten(input logic [DATA_WIDTH-1:0] biten);
        logic [STRB_W-1:0] strb;
        strb = {STRB_W{1'b0}};
        for (int i = 0; i < STRB_W; i++) begin
            strb[i] = |biten[8*i +: 8];
        end
        return strb;
    endfunction

    // Watchdog expiry: counter has reached the last allowed stalled cycle.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            timeout_hit_s = (wait_cnt_r == CNT_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= {CNT_W{1'b0}};
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            pwdata_r      <= {DATA_WIDTH{1'b0}};
            pstrb_r       <= {STRB_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rd_data_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        paddr_r    <= bus.i_addr;
                        pwrite_r   <= bus.i_req_is_wr;
                        pwdata_r   <= bus.i_wr_data;
                        pstrb_r    <= bus.i_req_is_wr ? strb_from_biten(bus.i_wr_biten) : {STRB_W{1'b0}};
                        psel_r     <= 1'b1;
                        penable_r  <= 1'b0;
                        wait_cnt_r <= {CNT_W{1'b0}};
                        state_r    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rd_data_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.prdata;
                        rsp_err_r     <= bus.pslverr;
                        state_r       <= ST_IDLE;
                    end else if (timeout_hit_s) begin
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rd_data_r <= {DATA_WIDTH{1'b0}};
                        rsp_err_r     <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else if (wait_cnt_r != CNT_MAX) begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready   = (state_r == ST_IDLE);
    assign bus.o_rsp_valid   = rsp_valid_r;
    assign bus.o_rsp_rd_data = rsp_rd_data_r;
    assign bus.o_rsp_err     = rsp_err_r;
    assign bus.paddr         = paddr_r;
    assign bus.psel          = psel_r;
    assign bus.penable       = penable_r;
    assign bus.pwrite        = pwrite_r;
    assign bus.pwdata        = pwdata_r;
    assign bus.pstrb         = pstrb_r;
    assign bus.pprot         = PPROT_VAL;
endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master: the bench plays requester and APB slave, and every
// expected value below is worked out by hand from the transfer timing.
module tb_apb4_master;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cnt;
    logic [7:0] psel_exp;
    logic [7:0] vld_exp;

    apb4_master_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus ();

    apb4_master #(
        .ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .PPROT_VAL(3'b010)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] addr, input logic [31:0] data, input logic [31:0] biten);
        bus.i_req       = 1'b1;
        bus.i_req_is_wr = wr;
        bus.i_addr      = addr;
        bus.i_wr_data   = data;
        bus.i_wr_biten  = biten;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_req_is_wr = 1'b0; bus.i_addr = 3'h0;
        bus.i_wr_data = 32'h0; bus.i_wr_biten = 32'h0;
        bus.pready = 1'b0; bus.prdata = 32'h0; bus.pslverr = 1'b0;
        step(); step();
        rst = 1'b0;
        check_eq("rst_psel",    64'(bus.psel), 64'h0);
        check_eq("rst_penable", 64'(bus.penable), 64'h0);
        check_eq("rst_ready",   64'(bus.o_req_ready), 64'h1);
        check_eq("rst_valid",   64'(bus.o_rsp_valid), 64'h0);
        check_eq("rst_paddr",   64'(bus.paddr), 64'h0);
        check_eq("rst_pwdata",  64'(bus.pwdata), 64'h0);
        check_eq("rst_pstrb",   64'(bus.pstrb), 64'h0);
        check_eq("pprot",       64'(bus.pprot), 64'h2);

        // Minimum-latency write; pready already high in SETUP must be ignored there.
        issue(1'b1, 3'h4, 32'hDEADBEEF, 32'h0000FFFF);
        bus.pready = 1'b1;
        step();
        bus.i_req = 1'b0;
        check_eq("wr_setup_psel",    64'(bus.psel), 64'h1);
        check_eq("wr_setup_penable", 64'(bus.penable), 64'h0);
        check_eq("wr_setup_pwrite",  64'(bus.pwrite), 64'h1);
        check_eq("wr_setup_pstrb",   64'(bus.pstrb), 64'h3);
        check_eq("wr_setup_paddr",   64'(bus.paddr), 64'h4);
        check_eq("wr_setup_pwdata",  64'(bus.pwdata), 64'hDEADBEEF);
        check_eq("wr_setup_ready",   64'(bus.o_req_ready), 64'h0);
        check_eq("wr_setup_valid",   64'(bus.o_rsp_valid), 64'h0);
        step();
        check_eq("wr_access_psel",    64'(bus.psel), 64'h1);
        check_eq("wr_access_penable", 64'(bus.penable), 64'h1);
        step();
        check_eq("wr_rsp_valid", 64'(bus.o_rsp_valid), 64'h1);
        check_eq("wr_rsp_err",   64'(bus.o_rsp_err), 64'h0);
        check_eq("wr_rsp_data",  64'(bus.o_rsp_rd_data), 64'h0);
        check_eq("wr_end_psel",  64'(bus.psel), 64'h0);
        check_eq("wr_end_ready", 64'(bus.o_req_ready), 64'h1);
        bus.pready = 1'b0;
        bus.i_addr = 3'h1;
        step();
        check_eq("wr_pulse_once", 64'(bus.o_rsp_valid), 64'h0);
        check_eq("idle_hold_paddr", 64'(bus.paddr), 64'h4);
        check_eq("idle_hold_pwdata", 64'(bus.pwdata), 64'hDEADBEEF);

        // Read stalled for three ACCESS cycles, completing on the fourth (one short of timeout).
        issue(1'b0, 3'h2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bus.prdata = 32'hBAD0BAD0;
        step();
        bus.i_req = 1'b0;
        check_eq("rd_setup_pstrb",  64'(bus.pstrb), 64'h0);
        check_eq("rd_setup_pwrite", 64'(bus.pwrite), 64'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("rd_wait_psel",    64'(bus.psel), 64'h1);
            check_eq("rd_wait_penable", 64'(bus.penable), 64'h1);
            check_eq("rd_wait_paddr",   64'(bus.paddr), 64'h2);
            if (i == 3) begin
                bus.pready = 1'b1;
                bus.prdata = 32'h12345678;
            end
            step();
        end
        check_eq("rd_rsp_valid", 64'(bus.o_rsp_valid), 64'h1);
        check_eq("rd_rsp_data",  64'(bus.o_rsp_rd_data), 64'h12345678);
        check_eq("rd_rsp_err",   64'(bus.o_rsp_err), 64'h0);
        check_eq("rd_end_psel",  64'(bus.psel), 64'h0);

        // Read completing with a slave error.
        issue(1'b0, 3'h3, 32'h0, 32'h0);
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hA5A5C3C3;
        step();
        bus.i_req = 1'b0;
        step();
        step();
        check_eq("err_rsp_valid", 64'(bus.o_rsp_valid), 64'h1);
        check_eq("err_rsp_err",   64'(bus.o_rsp_err), 64'h1);
        check_eq("err_rsp_data",  64'(bus.o_rsp_rd_data), 64'hA5A5C3C3);
        bus.pready = 1'b0;
        bus.pslverr = 1'b0;
        step();

        // Watchdog: pready never arrives, exactly four ACCESS cycles expected.
        issue(1'b0, 3'h5, 32'h0, 32'h0);
        bus.prdata = 32'h55555555;
        step();
        bus.i_req = 1'b0;
        step();
        cnt = 0;
        while (bus.penable === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        check_eq("to_access_cycles", 64'(cnt), 64'd4);
        check_eq("to_psel",          64'(bus.psel), 64'h0);
        check_eq("to_rsp_valid",     64'(bus.o_rsp_valid), 64'h1);
        check_eq("to_rsp_err",       64'(bus.o_rsp_err), 64'h1);
        check_eq("to_rsp_data",      64'(bus.o_rsp_rd_data), 64'h0);
        step();

        // Reset in ACCESS abandons the transfer silently.
        issue(1'b0, 3'h6, 32'h0, 32'h0);
        step();
        bus.i_req = 1'b0;
        step();
        check_eq("rstmid_in_access", 64'(bus.penable), 64'h1);
        rst = 1'b1;
        step();
        check_eq("rstmid_psel",    64'(bus.psel), 64'h0);
        check_eq("rstmid_penable", 64'(bus.penable), 64'h0);
        check_eq("rstmid_ready",   64'(bus.o_req_ready), 64'h1);
        check_eq("rstmid_valid",   64'(bus.o_rsp_valid), 64'h0);

        // Request accepted in the very first cycle after reset release.
        rst = 1'b0;
        issue(1'b1, 3'h7, 32'hCAFEF00D, 32'hFF000000);
        bus.pready = 1'b1;
        step();
        bus.i_req = 1'b0;
        check_eq("post_rst_psel",  64'(bus.psel), 64'h1);
        check_eq("post_rst_pstrb", 64'(bus.pstrb), 64'h8);
        check_eq("post_rst_paddr", 64'(bus.paddr), 64'h7);
        step();
        step();
        check_eq("post_rst_valid", 64'(bus.o_rsp_valid), 64'h1);
        step();

        // Back-to-back reads with i_req held high throughout.
        psel_exp = 8'b1011_0110;
        vld_exp  = 8'b0100_1000;
        issue(1'b0, 3'h1, 32'h0, 32'h0);
        bus.prdata = 32'h0000BEEF;
        for (int i = 0; i < 8; i++) begin
            check_eq("b2b_psel",  64'(bus.psel), 64'(psel_exp[i]));
            check_eq("b2b_valid", 64'(bus.o_rsp_valid), 64'(vld_exp[i]));
            step();
        end
        bus.i_req = 1'b0;
        cnt = 0;
        while (bus.o_rsp_valid !== 1'b1 && cnt < 10) begin
            cnt++;
            step();
        end
        check_eq("b2b_last_valid", 64'(bus.o_rsp_valid), 64'h1);
        check_eq("b2b_last_data",  64'(bus.o_rsp_rd_data), 64'h0000BEEF);
        bus.pready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
